mpx_scan: RTL

//  Parametrised registered N:1 channel multiplexer: successor to the fixed 4:1 combinational mux.

---
 rtl/mpx_scan_pkg.sv | 20 ++
 rtl/mpx_next_en.sv | 35 +++
 rtl/mpx_scan.sv | 105 ++++++++++
 3 files changed

// File: rtl/mpx_scan_pkg.sv
// Shared definitions for the mpx_scan channel multiplexer.
// Holds the controller state encoding and the width helpers.
package mpx_scan_pkg;

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        SCAN   = 2'd1,
        IDLE   = 2'd2
    } state_t;

    function automatic int selWidth(input int n);
        return $clog2(n);
    endfunction

    // One bit minimum so a single-cycle dwell still gets a legal counter.
    function automatic int cntWidth(input int dwell);
        return (dwell > 1) ? $clog2(dwell) : 1;
    endfunction

endpackage

// File: rtl/mpx_next_en.sv
// Rotate-priority search: returns the first enabled channel starting at
// i_start (inclusive) or just after it (exclusive), wrapping N-1 -> 0.
module mpx_next_en
    import mpx_scan_pkg::*;
#(
    parameter  int N  = 4,
    localparam int SW = selWidth(N)
) (
    input  logic [N-1:0]  i_enMask,
    input  logic [SW-1:0] i_start,
    input  logic          i_inclusive,
    output logic [SW-1:0] o_idx,
    output logic          o_found
);

    // An exclusive search over steps 1..N ends on i_start itself, so a lone
    // enabled channel finds itself again.
    always_comb begin
        int k;
        k       = 0;
        o_idx   = i_start;
        o_found = 1'b0;
        for (int step = 0; step < N; step++) begin
            k = int'(i_start) + step + (i_inclusive ? 0 : 1);
            if (k >= N) begin
                k = k - N;
            end
            if (!o_found && i_enMask[k[SW-1:0]]) begin
                o_found = 1'b1;
                o_idx   = k[SW-1:0];
            end
        end
    end

endmodule

// File: rtl/mpx_scan.sv
// Registered N:1 channel multiplexer with manual select and a dwell-timed
// scan over enabled channels; q and ch always update together.
module mpx_scan
    import mpx_scan_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int W     = 1,
    parameter  int DWELL = 7,
    localparam int SW    = selWidth(N)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_mode,
    input  logic [SW-1:0]  i_sel,
    input  logic [N-1:0]   i_enMask,
    input  logic [N*W-1:0] i_d,
    output logic [W-1:0]   o_q,
    output logic [SW-1:0]  o_ch,
    output logic           o_stb,
    output logic           o_idle
);

    localparam int CW = cntWidth(DWELL);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [SW-1:0]   r_ch;
    logic [W-1:0]    r_q;
    logic            r_stb;
    logic            r_idle;

    state_t          w_stateNxt;
    logic [CW-1:0]   w_cntNxt;
    logic [SW-1:0]   w_chNxt;
    logic [SW-1:0]   w_idx;
    logic            w_found;
    logic [W-1:0]    w_chan [N];

    for (genvar k = 0; k < N; k++) begin : g_chan
        assign w_chan[k] = i_d[k*W +: W];
    end

    // Entering scan from manual or idle keeps ch if it is enabled, so the
    // search is inclusive there; inside scan it always looks past ch.
    mpx_next_en #(.N(N)) u_nextEn (
        .i_enMask    (i_enMask),
        .i_start     (r_ch),
        .i_inclusive (r_state != SCAN),
        .o_idx       (w_idx),
        .o_found     (w_found)
    );

    // Mode is checked first so a mode change overrides a dwell expiry.
    always_comb begin
        w_stateNxt = r_state;
        w_cntNxt   = r_cnt;
        w_chNxt    = r_ch;
        if (!i_mode) begin
            w_stateNxt = MANUAL;
            w_cntNxt   = '0;
            if (int'(i_sel) < N) begin
                w_chNxt = i_sel;
            end
        end else if (!w_found) begin
            w_stateNxt = IDLE;
            w_cntNxt   = '0;
        end else if (r_state != SCAN) begin
            w_stateNxt = SCAN;
            w_cntNxt   = '0;
            w_chNxt    = w_idx;
        end else if (!i_enMask[r_ch] || (r_cnt == CW'(DWELL - 1))) begin
            w_cntNxt   = '0;
            w_chNxt    = w_idx;
        end else begin
            w_cntNxt   = r_cnt + 1'b1;
        end
    end

    // q freezes while idle; everywhere else it follows live data of ch_nxt.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= MANUAL;
            r_cnt   <= '0;
            r_ch    <= '0;
            r_q     <= '0;
            r_stb   <= 1'b0;
            r_idle  <= 1'b0;
        end else begin
            r_state <= w_stateNxt;
            r_cnt   <= w_cntNxt;
            r_ch    <= w_chNxt;
            r_stb   <= (w_chNxt != r_ch);
            r_idle  <= (w_stateNxt == IDLE);
            if (w_stateNxt != IDLE) begin
                r_q <= w_chan[w_chNxt];
            end
        end
    end

    assign o_q    = r_q;
    assign o_ch   = r_ch;
    assign o_stb  = r_stb;
    assign o_idle = r_idle;

endmodule
